// File: rtl/requant_shift_sequencer_if.sv
// Stream bundle for the requantizer: accumulator input stream and int8 output stream.
// The slave modport is the sequencer; the master side feeds inputs and sinks outputs.
interface requant_shift_sequencer_if #(
    parameter int ACC_W = 24
);
    logic                    in_valid;
    logic                    in_ready;
    logic signed [ACC_W-1:0] in_acc;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [7:0]       out_data;
    logic                    out_last;

    modport master (
        output in_valid, in_acc, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  in_valid, in_acc, out_ready,
        output in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/requant_shift_sequencer.sv
// Per-channel requantizer: shifts each accumulator by a signed ROM shift (rounding right
// or left), saturates to int8 and sequences channels/pixels for one layer.
module requant_shift_sequencer #(
    parameter int NUM_CH = 64,
    parameter int ACC_W  = 24
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              start,
    input  logic [15:0]                       num_pixels,
    requant_shift_sequencer_if.slave          io,
    output logic [5:0]                        rom_addr,
    input  logic [7:0]                        rom_data,
    output logic                              busy,
    output logic                              done
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    // Wide enough for acc + 2^30 rounding term and acc << 8 without overflow.
    localparam int W = (ACC_W + 9 > 33) ? ACC_W + 9 : 33;
    localparam logic signed [W-1:0] SAT_HI = W'(127);
    localparam logic signed [W-1:0] SAT_LO = -W'(128);
    localparam logic [5:0] LAST_CH = 6'(NUM_CH - 1);

    logic [1:0]        state_q, state_d;
    logic [5:0]        ch_q, ch_d;
    logic [15:0]       pix_q, pix_d;
    logic [15:0]       npix_q, npix_d;
    logic              out_valid_q, out_valid_d;
    logic signed [7:0] out_data_q, out_data_d;
    logic              out_last_q, out_last_d;
    logic              zdone_q, zdone_d;

    logic              in_ready;
    logic              accept;
    logic              is_last;

    logic signed [7:0]   shamt;
    logic [4:0]          rsh;
    logic [3:0]          lsh;
    logic signed [W-1:0] acc_ext;
    logic signed [W-1:0] rnd;
    logic signed [W-1:0] shifted;
    logic signed [7:0]   q8;

    assign in_ready = (state_q == S_RUN) && (!out_valid_q || io.out_ready);
    assign accept   = io.in_valid && in_ready;
    assign is_last  = (ch_q == LAST_CH) && (pix_q == npix_q - 16'd1);

    always_comb begin
        shamt   = $signed(rom_data);
        acc_ext = {{(W-ACC_W){io.in_acc[ACC_W-1]}}, io.in_acc};
        rsh     = (shamt > 8'sd31) ? 5'd31 : shamt[4:0];
        lsh     = (shamt < -8'sd8) ? 4'd8 : 4'(-shamt);
        rnd     = '0;
        shifted = acc_ext;
        if (shamt > 8'sd0) begin
            rnd     = {{(W-1){1'b0}}, 1'b1} << (rsh - 5'd1);
            shifted = (acc_ext + rnd) >>> rsh;
        end else if (shamt < 8'sd0) begin
            shifted = acc_ext <<< lsh;
        end
        if (shifted > SAT_HI)      q8 = 8'sh7f;
        else if (shifted < SAT_LO) q8 = 8'sh80;
        else                       q8 = shifted[7:0];
    end

    always_comb begin
        state_d     = state_q;
        ch_d        = ch_q;
        pix_d       = pix_q;
        npix_d      = npix_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        zdone_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (num_pixels != 16'd0) begin
                        state_d = S_RUN;
                        npix_d  = num_pixels;
                        ch_d    = '0;
                        pix_d   = '0;
                    end else begin
                        zdone_d = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (accept) begin
                    if (ch_q == LAST_CH) begin
                        ch_d  = '0;
                        pix_d = pix_q + 16'd1;
                    end else begin
                        ch_d  = ch_q + 6'd1;
                    end
                    if (is_last) state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (out_valid_q && io.out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // A fresh accept always refills the output register; otherwise a consume empties it.
        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = q8;
            out_last_d  = is_last;
        end else if (io.out_ready) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            ch_q        <= '0;
            pix_q       <= '0;
            npix_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            zdone_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            ch_q        <= ch_d;
            pix_q       <= pix_d;
            npix_q      <= npix_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            zdone_q     <= zdone_d;
        end
    end

    assign io.in_ready  = in_ready;
    assign io.out_valid = out_valid_q;
    assign io.out_data  = out_data_q;
    assign io.out_last  = out_last_q;
    assign rom_addr     = ch_q;
    assign busy         = (state_q != S_IDLE);
    assign done         = zdone_q || ((state_q == S_DRAIN) && out_valid_q && io.out_ready);
endmodule

// File: doc/requant_shift_sequencer.md
REQUANT_SHIFT_SEQUENCER -- requirements
Module: requant_shift_sequencer

Interface
REQ-001 SHALL have parameter NUM_CH, default 64, meaning channels per pixel and shift-ROM depth.
REQ-002 SHALL have parameter ACC_W, default 24, meaning signed accumulator width.
REQ-003 SHALL have port clk  input  1  meaning sole clock, rising edge.
REQ-004 SHALL have port rst_n  input  1  meaning asynchronous active-low reset.
REQ-005 SHALL have port start  input  1  meaning one-cycle layer start pulse.
REQ-006 SHALL have port num_pixels  input  16  meaning pixel count, latched on accepted start.
REQ-007 SHALL have port in_valid  input  1  meaning in_acc valid.
REQ-008 SHALL have port in_ready  output  1  meaning block accepts in_acc.
REQ-009 SHALL have port in_acc  input  ACC_W  meaning signed accumulator, channel order 0..NUM_CH-1 per pixel.
REQ-010 SHALL have port rom_addr  output  6  meaning shift-ROM address, equals the current channel count.
REQ-011 SHALL have port rom_data  input  8  meaning combinational shift-ROM read data, signed.
REQ-012 SHALL have port out_valid  output  1  meaning out_data valid.
REQ-013 SHALL have port out_ready  input  1  meaning downstream accepts out_data.
REQ-014 SHALL have port out_data  output  8  meaning signed requantized int8.
REQ-015 SHALL have port out_last  output  1  meaning out_data is the final element of the layer.
REQ-016 SHALL have port busy  output  1  meaning state is not IDLE.
REQ-017 SHALL have port done  output  1  meaning one-cycle pulse on layer completion.

Function
REQ-018 SHALL implement states IDLE, RUN, DRAIN.
REQ-019 SHALL go IDLE->RUN on start with num_pixels!=0, latching num_pixels and clearing the channel and pixel counters.
REQ-020 SHALL, on start with num_pixels==0, stay in IDLE and pulse done in the next cycle, producing no output.
REQ-021 SHALL ignore start outside IDLE.
REQ-022 SHALL drive in_ready = (state==RUN) && (!out_valid || out_ready).
REQ-023 SHALL accept an input on in_valid && in_ready, registering the result to out_data and setting out_valid on the same edge (latency 1 cycle).
REQ-024 SHALL clear out_valid when out_ready && out_valid with no new accept; out_data, out_valid and out_last SHALL hold stable while out_valid && !out_ready.
REQ-025 SHALL increment the channel counter on each accept, wrapping from NUM_CH-1 to 0 and incrementing the pixel counter on wrap.
REQ-026 SHALL set out_last with the accept of channel NUM_CH-1 of pixel num_pixels-1, and go RUN->DRAIN on that accept.
REQ-027 SHALL go DRAIN->IDLE when the last output is consumed (out_valid && out_ready), pulsing done in the same cycle.
REQ-028 SHALL decode shift s = signed rom_data: s>0 gives a rounding arithmetic right shift (acc + 2^(min(s,31)-1)) >>> min(s,31).
REQ-029 SHALL, for s<0, left-shift acc by min(-s,8); for s==0, pass acc unchanged.
REQ-030 SHALL compute in at least ACC_W+9 signed bits without overflow, then saturate to [-128,127].

Reset
REQ-031 SHALL, on rst_n low, asynchronously force state IDLE, clear both counters, and drive in_ready=0, out_valid=0, out_data=0, out_last=0, busy=0, done=0, rom_addr=0.
REQ-032 SHALL, on reset mid-layer, discard all in-flight data and require a new start.

Verification
REQ-033 SHALL verify: rom[0]=0x14, in_acc=1572864 on channel 0 -> out_data=2 one cycle after accept.
REQ-034 SHALL verify: rom[3]=0xEE (s=-18, clamped to 8), in_acc=1 -> out_data=127 (saturated); in_acc=-1 -> out_data=-128.
REQ-035 SHALL verify: rom[1]=0x54 (s=84, clamped to 31), in_acc=-1000 -> out_data=0.
REQ-036 SHALL verify: num_pixels=2, 128 inputs with out_ready held low for 5 cycles mid-stream -> output held stable, no loss, rom_addr wraps 63->0, out_last only on the 128th output, done one cycle-pulse when it is consumed.
REQ-037 SHALL verify: start with num_pixels=0 -> done pulse next cycle, busy stays 0; start during RUN -> ignored.
REQ-038 SHALL verify: rst_n low at input 40 -> outputs take reset values immediately; a fresh start then begins at rom_addr=0.
